// File: rtl/four_bit_serial_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM state
// encoding and the default operand width.
package four_bit_serial_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : four_bit_serial_pkg

// File: rtl/full_adder.sv
// Single-bit full adder. This is the only arithmetic element in the serial
// datapath. One operand bit pair is consumed each cycle.
module full_adder (
  input  logic A_i,
  input  logic B_i,
  input  logic C_i,
  output logic S_o,
  output logic C_o
);

  // Sum and majority-carry of the three input bits.
  always_comb begin
    S_o = A_i ^ B_i ^ C_i;
    C_o = (A_i & B_i) | (A_i & C_i) | (B_i & C_i);
  end

endmodule : full_adder

// File: rtl/four_bit_serial_add_sub.sv
// Bit-serial adder/subtractor with valid/ready handshakes on both sides.
// An accepted request is processed LSB first, one bit per cycle, through a
// single full adder. The result is presented until the consumer takes it.
// Subtraction is A + ~B + ~C_i. The inversion of B and of the carry-in is
// applied once, when the request is accepted, so the serial loop is the
// same for both operations.
module four_bit_serial_add_sub
  import four_bit_serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  input  logic             C_i,
  input  logic             SUB_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] S_o,
  output logic             C_o,
  output logic             V_o
);

  localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t state;
  state_t next_state;

  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] a_q;      // remaining bits of A, consumed from bit 0
  logic [WIDTH-1:0] b_q;      // remaining bits of the effective B
  logic [WIDTH-1:0] s_q;      // result, filled from the MSB end
  logic             sub_q;
  logic             carry_q;  // carry into the bit being processed
  logic             c_q;
  logic             v_q;

  logic             fa_sum;
  logic             fa_cout;
  logic             last_bit;

  assign last_bit = (bit_cnt == LAST_BIT);

  full_adder u_full_adder (
    .A_i (a_q[0]),
    .B_i (b_q[0]),
    .C_i (carry_q),
    .S_o (fa_sum),
    .C_o (fa_cout)
  );

  // State register. Reset takes priority over any handshake on the same edge.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments only. Every flop
    // then samples values from before the edge, regardless of block order.
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. The handshake outputs are decoded from the state
  // register alone, so no input reaches them combinationally.
  always_comb begin
    // NOTE: each output gets a default before the case. This way no path
    // leaves a variable unassigned, and no latch is inferred.
    next_state = state;
    ready_o    = 1'b0;
    valid_o    = 1'b0;
    case (state)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_i) begin
          next_state = RUN;
        end
      end
      RUN: begin
        if (last_bit) begin
          next_state = DONE;
        end
      end
      DONE: begin
        valid_o = 1'b1;
        if (ready_i) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Datapath: capture the operands on accept, then run one serial step per
  // RUN cycle. The flags are committed on the final bit.
  always_ff @(posedge clk_i) begin
    // NOTE: only registers that are visible at the outputs, plus the bit
    // counter, are reset. The operand and carry registers are always loaded
    // on accept before they are used, so resetting them would add nothing.
    if (rst_i) begin
      bit_cnt <= '0;
      s_q     <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_i) begin
            a_q     <= A_i;
            b_q     <= B_i ^ {WIDTH{SUB_i}};
            carry_q <= C_i ^ SUB_i;
            sub_q   <= SUB_i;
            bit_cnt <= '0;
          end
        end
        RUN: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          carry_q <= fa_cout;
          s_q     <= {fa_sum, s_q[WIDTH-1:1]};
          bit_cnt <= bit_cnt + CNT_ONE;
          if (last_bit) begin
            // A subtract reports a borrow, which is the inverted final carry.
            c_q <= fa_cout ^ sub_q;
            // Overflow compares the carry into the MSB with the carry out of it.
            v_q <= carry_q ^ fa_cout;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign S_o = s_q;
  assign C_o = c_q;
  assign V_o = v_q;

endmodule : four_bit_serial_add_sub

// File: tb/tb_four_bit_serial_add_sub.sv
// Directed testbench for four_bit_serial_add_sub at the default width.
// Inputs are driven, and outputs sampled, 1 time unit after each rising edge.
module tb_four_bit_serial_add_sub;

  localparam int W = 4;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic         valid_i = 1'b0;
  logic         ready_o;
  logic [W-1:0] A_i = '0;
  logic [W-1:0] B_i = '0;
  logic         C_i = 1'b0;
  logic         SUB_i = 1'b0;
  logic         valid_o;
  logic         ready_i = 1'b0;
  logic [W-1:0] S_o;
  logic         C_o;
  logic         V_o;

  int checks = 0;
  int errors = 0;

  four_bit_serial_add_sub #(.WIDTH(W)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .A_i     (A_i),
    .B_i     (B_i),
    .C_i     (C_i),
    .SUB_i   (SUB_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .S_o     (S_o),
    .C_o     (C_o),
    .V_o     (V_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Presents one request to an idle DUT and waits, within a bound, for
  // valid_o. Returns the result and the number of edges from accept to
  // valid. If the bound expires, lat is returned as -1.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic sub,
                        output logic [W-1:0] s, output logic co,
                        output logic vo, output int lat);
    A_i = a; B_i = b; C_i = c; SUB_i = sub; valid_i = 1'b1; ready_i = 1'b0;
    tick();
    valid_i = 1'b0;
    lat = 0;
    while (!valid_o && lat < 20) begin
      tick();
      lat++;
    end
    if (!valid_o) lat = -1;
    s = S_o; co = C_o; vo = V_o;
  endtask

  task automatic finish_op();
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    valid_i = 1'b1;  // reset must win over a concurrent request
    tick();
    tick();
    rst_i = 1'b0;
    valid_i = 1'b0;
    checks++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake: ready_o=%b valid_o=%b expected 1/0", ready_o, valid_o);
    end
    checks++;
    if (S_o !== 4'h0 || C_o !== 1'b0 || V_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: S=%h C=%b V=%b expected 0/0/0", S_o, C_o, V_o);
    end
  endtask

  task automatic test_add();
    logic [W-1:0] s; logic co, vo; int lat;
    run_op(4'h7, 4'h9, 1'b0, 1'b0, s, co, vo, lat);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL add_latency: got %0d expected 4", lat);
    end
    checks++;
    if (s !== 4'h0 || co !== 1'b1 || vo !== 1'b0) begin
      errors++;
      $display("FAIL add_7_9: S=%h C=%b V=%b expected 0/1/0", s, co, vo);
    end
    checks++;
    if (ready_o !== 1'b0) begin
      errors++;
      $display("FAIL add_ready_in_done: ready_o=%b expected 0", ready_o);
    end
    finish_op();
    checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1 || S_o !== 4'h0 || C_o !== 1'b1) begin
      errors++;
      $display("FAIL add_idle_hold: valid=%b ready=%b S=%h C=%b expected 0/1/0/1",
               valid_o, ready_o, S_o, C_o);
    end
  endtask

  task automatic test_sub();
    logic [W-1:0] s; logic co, vo; int lat;
    run_op(4'h3, 4'h5, 1'b0, 1'b1, s, co, vo, lat);
    checks++;
    if (lat !== 4 || s !== 4'hE || co !== 1'b1 || vo !== 1'b0) begin
      errors++;
      $display("FAIL sub_3_5: lat=%0d S=%h C=%b V=%b expected 4/E/1/0", lat, s, co, vo);
    end
    finish_op();
    run_op(4'h8, 4'h1, 1'b0, 1'b1, s, co, vo, lat);
    checks++;
    if (lat !== 4 || s !== 4'h7 || co !== 1'b0 || vo !== 1'b1) begin
      errors++;
      $display("FAIL sub_8_1: lat=%0d S=%h C=%b V=%b expected 4/7/0/1", lat, s, co, vo);
    end
    finish_op();
  endtask

  task automatic test_overflow();
    logic [W-1:0] s; logic co, vo; int lat;
    run_op(4'h7, 4'h0, 1'b1, 1'b0, s, co, vo, lat);
    checks++;
    if (lat !== 4 || s !== 4'h8 || co !== 1'b0 || vo !== 1'b1) begin
      errors++;
      $display("FAIL ovf_7_0_cin: lat=%0d S=%h C=%b V=%b expected 4/8/0/1", lat, s, co, vo);
    end
    finish_op();
  endtask

  task automatic test_backpressure();
    logic [W-1:0] s; logic co, vo; int lat;
    // 5 + 6 = 11: the result is 4'hB, carry 0, and it overflows signed.
    run_op(4'h5, 4'h6, 1'b0, 1'b0, s, co, vo, lat);
    checks++;
    if (lat !== 4 || s !== 4'hB || co !== 1'b0 || vo !== 1'b1) begin
      errors++;
      $display("FAIL bp_result: lat=%0d S=%h C=%b V=%b expected 4/B/0/1", lat, s, co, vo);
    end
    for (int i = 0; i < 3; i++) begin
      // Disturb the request side. The block must ignore it while in DONE.
      valid_i = 1'b1; A_i = 4'hF; B_i = 4'hF; SUB_i = 1'b1;
      tick();
      checks++;
      if (valid_o !== 1'b1 || ready_o !== 1'b0 || S_o !== 4'hB || C_o !== 1'b0 || V_o !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold_%0d: valid=%b ready=%b S=%h C=%b V=%b expected 1/0/B/0/1",
                 i, valid_o, ready_o, S_o, C_o, V_o);
      end
    end
    valid_i = 1'b0;
    finish_op();
    checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1 || S_o !== 4'hB) begin
      errors++;
      $display("FAIL bp_release: valid=%b ready=%b S=%h expected 0/1/B", valid_o, ready_o, S_o);
    end
  endtask

  task automatic test_mid_reset();
    logic [W-1:0] s; logic co, vo; int lat;
    logic seen_valid;
    A_i = 4'hF; B_i = 4'hF; C_i = 1'b1; SUB_i = 1'b0; valid_i = 1'b1;
    tick();                 // accept
    valid_i = 1'b0;
    tick();                 // bit 0
    tick();                 // bit 1
    rst_i = 1'b1;
    tick();                 // reset at the edge that would process bit 2
    rst_i = 1'b0;
    checks++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0 || S_o !== 4'h0 || C_o !== 1'b0 || V_o !== 1'b0) begin
      errors++;
      $display("FAIL midrst_state: ready=%b valid=%b S=%h C=%b V=%b expected 1/0/0/0/0",
               ready_o, valid_o, S_o, C_o, V_o);
    end
    seen_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (valid_o) seen_valid = 1'b1;
    end
    checks++;
    if (seen_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_no_valid: valid_o pulsed after abort, expected none");
    end
    run_op(4'h1, 4'h1, 1'b0, 1'b0, s, co, vo, lat);
    checks++;
    if (lat !== 4 || s !== 4'h2 || co !== 1'b0 || vo !== 1'b0) begin
      errors++;
      $display("FAIL midrst_1_1: lat=%0d S=%h C=%b V=%b expected 4/2/0/0", lat, s, co, vo);
    end
    finish_op();
  endtask

  task automatic test_back_to_back();
    // Columns: a, b, c, sub, expected s, c, v
    logic [W-1:0] va [4] = '{4'h7, 4'hA, 4'h2, 4'h0};
    logic [W-1:0] vb [4] = '{4'h9, 4'h3, 4'h1, 4'h1};
    logic         vc [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic         vs [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [W-1:0] es [4] = '{4'h0, 4'hE, 4'h0, 4'hF};
    logic         ec [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic         ev [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    int acc_cyc [4];
    int cyc = 0;
    int n_acc = 0;
    int n_res = 0;
    logic will_accept;
    ready_i = 1'b1;
    while (n_res < 4 && cyc < 100) begin
      will_accept = 1'b0;
      if (n_acc < 4) begin
        valid_i = 1'b1;
        A_i = va[n_acc]; B_i = vb[n_acc]; C_i = vc[n_acc]; SUB_i = vs[n_acc];
        will_accept = ready_o;
      end else begin
        valid_i = 1'b0;
      end
      tick();
      cyc++;
      if (will_accept) begin
        acc_cyc[n_acc] = cyc;
        if (n_acc > 0) begin
          checks++;
          if (acc_cyc[n_acc] - acc_cyc[n_acc-1] !== 6) begin
            errors++;
            $display("FAIL b2b_spacing_%0d: got %0d expected 6", n_acc,
                     acc_cyc[n_acc] - acc_cyc[n_acc-1]);
          end
        end
        n_acc++;
      end
      if (valid_o && n_res < n_acc) begin
        checks++;
        if (cyc - acc_cyc[n_res] !== 4 || S_o !== es[n_res] || C_o !== ec[n_res] || V_o !== ev[n_res]) begin
          errors++;
          $display("FAIL b2b_result_%0d: lat=%0d S=%h C=%b V=%b expected 4/%h/%b/%b", n_res,
                   cyc - acc_cyc[n_res], S_o, C_o, V_o, es[n_res], ec[n_res], ev[n_res]);
        end
        n_res++;
      end
    end
    valid_i = 1'b0;
    checks++;
    if (n_res !== 4) begin
      errors++;
      $display("FAIL b2b_timeout: got %0d results expected 4", n_res);
    end
    ready_i = 1'b0;
    tick();
  endtask

  initial begin
    tick();
    test_reset();
    test_add();
    test_sub();
    test_overflow();
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_four_bit_serial_add_sub

// File: doc/four_bit_serial_add_sub.md
FOUR_BIT_SERIAL_ADD_SUB -- requirements
Module: four_bit_serial_add_sub

Interface
REQ-001 Parameter: WIDTH, default 4, operand and result width in bits; legal range 2..16.
REQ-002 Port: clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst_i  input  1  reset; synchronous and active-high.
REQ-004 Port: valid_i  input  1  operand request valid.
REQ-005 Port: ready_o  output  1  block can accept a request.
REQ-006 Port: A_i  input  WIDTH  operand A, unsigned/two's complement.
REQ-007 Port: B_i  input  WIDTH  operand B.
REQ-008 Port: C_i  input  1  carry-in (add) or borrow-in (subtract).
REQ-009 Port: SUB_i  input  1  0 = add, 1 = subtract; sampled with operands.
REQ-010 Port: valid_o  output  1  result valid.
REQ-011 Port: ready_i  input  1  downstream accepts result.
REQ-012 Port: S_o  output  WIDTH  sum/difference.
REQ-013 Port: C_o  output  1  carry-out (add) or borrow-out (subtract).
REQ-014 Port: V_o  output  1  two's-complement overflow flag.

Function
REQ-015 The FSM SHALL have exactly three states, IDLE, RUN and DONE, with IDLE as the reset state.
REQ-016 The block SHALL drive ready_o high only in IDLE and drive valid_o high only in DONE.
REQ-017 An accept SHALL occur on a rising edge with valid_i and ready_o high: A_i, B_i, C_i and SUB_i are registered, the bit counter is cleared, and the state goes IDLE->RUN.
REQ-018 In RUN, the block SHALL process one bit per cycle, LSB first, through a single 1-bit full adder, and shift the result bit into the S register from the MSB end.
REQ-019 The add operation SHALL compute {C_o,S_o} = A + B + C_i, with C_i as the initial carry.
REQ-020 The subtract operation SHALL compute A + ~B + ~C_i, so that S_o = A - B - C_i; C_o SHALL be the inverted final carry, i.e. the borrow-out.
REQ-021 V_o SHALL equal the carry into the MSB XOR the carry out of the MSB, evaluated on the effective (possibly inverted) B.
REQ-022 The state SHALL go RUN->DONE on the edge that processes bit WIDTH-1, so that valid_o rises exactly WIDTH cycles after the accept edge.
REQ-023 In DONE, S_o, C_o, V_o and valid_o SHALL hold stable until ready_i is high on an edge; the state then goes DONE->IDLE.
REQ-024 A new accept SHALL NOT occur in the same cycle as the result handshake, giving a minimum request-to-request spacing of WIDTH+2 cycles.
REQ-025 The block SHALL ignore changes on valid_i and the operand inputs while it is in RUN or DONE.
REQ-026 S_o, C_o and V_o SHALL hold their last result while the block is in IDLE.

Reset
REQ-027 With rst_i high on an edge, the block SHALL enter IDLE and clear the bit counter, S_o, C_o, V_o and valid_o to 0, with ready_o at 1 after that edge.
REQ-028 A reset during RUN or DONE SHALL abort the operation and discard the pending result; no valid_o pulse may follow.
REQ-029 Reset SHALL take priority over a simultaneous accept or result handshake.

Structure
REQ-030 The state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH SHALL be defined in a shared package, four_bit_serial_pkg.
REQ-031 The 1-bit full adder SHALL be a separate sub-module, full_adder, with ports A_i, B_i, C_i, S_o and C_o, instantiated once.
REQ-032 The bit counter SHALL be $clog2(WIDTH) bits wide, and the datapath SHALL have no combinational path from any input to valid_o or ready_o.

Verification
REQ-033 Add case: A=4'h7, B=4'h9, C_i=0, SUB=0 -> S_o=4'h0, C_o=1, V_o=0, with valid_o exactly 4 cycles after accept.
REQ-034 Subtract case: A=4'h3, B=4'h5, C_i=0, SUB=1 -> S_o=4'hE, C_o=1 (borrow), V_o=0; then A=4'h8, B=4'h1 -> S_o=4'h7, V_o=1.
REQ-035 Overflow and carry-in case: A=4'h7, B=4'h0, C_i=1, SUB=0 -> S_o=4'h8, C_o=0, V_o=1.
REQ-036 Backpressure case: hold ready_i low for 3 cycles in DONE -> outputs stable and valid_o high throughout, with ready_o low; with ready_i high -> IDLE on the next edge.
REQ-037 Mid-operation reset: assert rst_i at RUN bit 2 -> IDLE, all outputs 0, no valid_o; a following request 4'h1+4'h1 -> S_o=4'h2.
REQ-038 Back-to-back case: hold valid_i high continuously with ready_i=1 -> accepts spaced 6 cycles apart, each result correct.
